// File: rtl/axis_rr_arbiter.sv
// Round-robin packet arbiter: shares one AXI-Stream master link among NUM_REQ requesters,
// holding the grant for a whole packet and capping packet length at MAX_BURST beats.
module axis_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                          aclk,
    input  logic                          areset_n,
    input  logic [NUM_REQ-1:0]            s_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_REQ-1:0]            s_last,
    output logic [NUM_REQ-1:0]            s_ready,
    output logic                          tvalid,
    output logic [DATA_WIDTH-1:0]         tdata,
    output logic                          tlast,
    input  logic                          tready,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          trunc
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW = $clog2(MAX_BURST);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

    typedef enum logic [0:0] {StIdle, StXfer} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
    logic               trunc_q, trunc_d;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      win;
    logic               win_found;
    logic               accept;
    int                 j;

    // Index of the current owner and the next round-robin winner after ptr_q.
    always_comb begin
        gidx      = '0;
        win       = '0;
        win_found = 1'b0;
        j         = 0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q[i]) gidx = IW'(i);
        end
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            j = (int'(ptr_q) + k) % int'(NUM_REQ);
            if (!win_found && s_valid[j]) begin
                win_found = 1'b1;
                win       = IW'(j);
            end
        end
    end

    always_comb begin
        tvalid  = 1'b0;
        tdata   = '0;
        tlast   = 1'b0;
        s_ready = '0;
        if (state_q == StXfer) begin
            tvalid  = s_valid[gidx];
            tdata   = s_data[gidx*DATA_WIDTH +: DATA_WIDTH];
            tlast   = s_last[gidx] | (beat_cnt_q == LAST_CNT);
            s_ready = grant_q & {NUM_REQ{tready}};
        end
    end

    assign accept = tvalid & tready;
    assign grant  = grant_q;
    assign busy   = (state_q == StXfer);
    assign trunc  = trunc_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        trunc_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    grant_d    = '0;
                    grant_d[win] = 1'b1;
                    ptr_d      = win;
                    beat_cnt_d = '0;
                    state_d    = StXfer;
                end
            end
            StXfer: begin
                if (accept) begin
                    if (tlast) begin
                        state_d    = StIdle;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                        // A forced tlast without the requester's own last is a cut packet.
                        trunc_d    = ~s_last[gidx];
                    end else if (beat_cnt_q != LAST_CNT) begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset is asserted while areset_n is high.
    always_ff @(posedge aclk or posedge areset_n) begin
        if (areset_n) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            ptr_q      <= IW'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            trunc_q    <= trunc_d;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: directed scenarios plus randomized packets, checked against a
// packet-level round-robin model of the expected output beat stream.
module tb_axis_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int MB = 16;

    logic            aclk = 1'b0;
    logic            areset_n = 1'b1;
    logic [N-1:0]    s_valid = '0;
    logic [N*DW-1:0] s_data = '0;
    logic [N-1:0]    s_last = '0;
    logic [N-1:0]    s_ready;
    logic            tvalid;
    logic [DW-1:0]   tdata;
    logic            tlast;
    logic            tready = 1'b0;
    logic [N-1:0]    grant;
    logic            busy;
    logic            trunc;

    axis_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .aclk    (aclk),
        .areset_n(areset_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .tvalid  (tvalid),
        .tdata   (tdata),
        .tlast   (tlast),
        .tready  (tready),
        .grant   (grant),
        .busy    (busy),
        .trunc   (trunc)
    );

    always #5 aclk = ~aclk;

    typedef struct {logic [DW-1:0] data; logic last;} beat_t;
    typedef struct {int idx; logic [DW-1:0] data; logic last; logic trunc;} exp_t;

    beat_t  srcq[N][$];
    exp_t   expq[$];
    bit     tready_seq[$];
    bit     tready_rand;
    int     model_ptr;
    logic   exp_trunc;
    int     checks;
    int     failures;
    int     cyc;
    int     test_id;
    int     last_acc_cyc;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Packet-level model: rotate among requesters with data, one grant per packet or MB beats.
    task automatic model_build();
        beat_t cq[N][$];
        int    w, cnt, jj;
        beat_t b;
        exp_t  e;
        for (int i = 0; i < N; i++) cq[i] = srcq[i];
        forever begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                jj = (model_ptr + k) % N;
                if (w < 0 && cq[jj].size() > 0) w = jj;
            end
            if (w < 0) break;
            model_ptr = w;
            cnt = 0;
            e.last = 1'b0;
            while (!e.last && cq[w].size() > 0) begin
                b = cq[w].pop_front();
                cnt++;
                e.idx   = w;
                e.data  = b.data;
                e.last  = b.last || (cnt == MB);
                e.trunc = (cnt == MB) && !b.last;
                expq.push_back(e);
            end
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                s_valid[i]          = 1'b1;
                s_data[i*DW +: DW]  = srcq[i][0].data;
                s_last[i]           = srcq[i][0].last;
            end else begin
                s_valid[i]          = 1'b0;
                s_data[i*DW +: DW]  = '0;
                s_last[i]           = 1'b0;
            end
        end
        if (tready_seq.size() > 0) tready = tready_seq.pop_front();
        else tready = tready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic run_cycle();
        logic [N-1:0] acc;
        exp_t e;
        @(negedge aclk);
        drive_inputs();
        #1;
        chk("trunc", trunc, exp_trunc);
        exp_trunc = 1'b0;
        if (tvalid && tready) begin
            if (expq.size() == 0) begin
                chk("spurious_beat", tvalid, 0);
            end else begin
                e = expq.pop_front();
                chk("grant", grant, 1 << e.idx);
                chk("tdata", tdata, e.data);
                chk("tlast", tlast, e.last);
                exp_trunc = e.trunc;
                if (test_id == 3 && last_acc_cyc >= 0) chk("gap", cyc - last_acc_cyc, 2);
                last_acc_cyc = cyc;
            end
        end
        if (test_id == 5 && cyc >= 1 && cyc <= 4) begin
            chk("t5_grant", grant, 4'b1000);
            chk("t5_sready", s_ready, {tready, 3'b000});
        end
        acc = s_valid & s_ready;
        @(posedge aclk);
        for (int i = 0; i < N; i++) if (acc[i]) void'(srcq[i].pop_front());
        cyc++;
    endtask

    function automatic bit pending();
        bit p = (expq.size() > 0);
        for (int i = 0; i < N; i++) if (srcq[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic run_test(input int id);
        test_id      = id;
        cyc          = 0;
        last_acc_cyc = -1;
        model_build();
        while (pending() && cyc < 2000) run_cycle();
        if (pending()) chk("timeout", expq.size(), 0);
        run_cycle();
        chk("idle_after", busy, 0);
    endtask

    task automatic push_pkt(input int r, input logic [DW-1:0] base, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = base + k;
            b.last = (k == len - 1);
            srcq[r].push_back(b);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) srcq[i].delete();
        expq.delete();
        tready_seq.delete();
        model_ptr = N - 1;
        exp_trunc = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset_n = 1'b1;
        s_valid  = '0;
        clear_model();
        repeat (2) @(negedge aclk);
        areset_n = 1'b0;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        tready_rand = 1'b0;
        test_id     = 0;
        clear_model();

        // 1: reset held with every requester valid, then release.
        s_valid = '1;
        s_last  = '1;
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = 32'hA0 + i;
        tready = 1'b0;
        repeat (5) @(negedge aclk);
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trunc", trunc, 0);
        chk("rst_tdata", tdata, 0);
        areset_n = 1'b0;
        @(negedge aclk);
        #1;
        chk("rel_grant", grant, 4'b0001);
        chk("rel_tvalid", tvalid, 1);
        do_reset();

        // 2: single requester, three-beat packet.
        push_pkt(1, 32'h1111_0001, 3);
        run_test(2);

        // 3: all requesters hold one-beat packets; requester 0 has a second one.
        do_reset();
        for (int i = 0; i < N; i++) push_pkt(i, 32'hA0 + i, 1);
        push_pkt(0, 32'hA0, 1);
        run_test(3);

        // 4: 20-beat packet is cut at 16 and the tail goes out as a new grant.
        push_pkt(2, 32'h2222_0001, 20);
        run_test(4);

        // 5: downstream stalls in the middle of a two-beat packet.
        push_pkt(3, 32'hCCCC_DDDD, 1);
        push_pkt(3, 32'hCCCC_DDDD, 1);
        srcq[3][0].last = 1'b0;
        tready_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        run_test(5);

        // 6: reset on beat 2 of 4, then requester 0 wins first.
        push_pkt(2, 32'h6666_0001, 4);
        test_id = 6;
        cyc = 0;
        last_acc_cyc = -1;
        model_build();
        run_cycle();
        run_cycle();
        @(negedge aclk);
        drive_inputs();
        #1;
        chk("t6_beat2", tdata, 32'h6666_0002);
        chk("t6_grant", grant, 4'b0100);
        areset_n = 1'b1;
        #1;
        chk("t6_rst_tvalid", tvalid, 0);
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_sready", s_ready, 0);
        chk("t6_rst_busy", busy, 0);
        clear_model();
        s_valid = '0;
        @(negedge aclk);
        areset_n = 1'b0;
        push_pkt(3, 32'h3333_0001, 1);
        push_pkt(0, 32'h0000_0001, 1);
        run_test(6);

        // Randomized packets with random downstream backpressure.
        tready_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                int np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) push_pkt(i, $urandom, $urandom_range(1, 24));
            end
            run_test(10 + r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
